// File: rtl/fuf_pkg.sv
// Shared FUF forwarding types and default sizing, also used by the capture-side forward mux.
package fuf_pkg;

    localparam int unsigned FUF_BUSES = 10;
    localparam int unsigned FUF_PORTS = 6;
    localparam int unsigned FUF_REG_W = 9;

    typedef logic [3:0]           fuf_sel_t;
    typedef logic [FUF_REG_W-1:0] fuf_tag_t;

    localparam fuf_sel_t FUF_NONE = 4'hF;

endpackage

// File: rtl/fuf_prio_match.sv
// Compares one source tag against every FUF bus announcement.
// Reports a hit and the lowest matching bus index.
module fuf_prio_match
    import fuf_pkg::*;
#(
    parameter int unsigned BUSES = FUF_BUSES,
    parameter int unsigned REG_W = FUF_REG_W
) (
    input  logic [BUSES-1:0]       valid,
    input  logic [BUSES*REG_W-1:0] tags,
    input  logic [REG_W-1:0]       key,
    output logic                   hit,
    output fuf_sel_t               idx
);

    // Scan from the top bus down so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = FUF_NONE;
        for (int unsigned i = BUSES; i > 0; i--) begin
            if (valid[i-1] && (tags[(i-1)*REG_W +: REG_W] == key)) begin
                hit = 1'b1;
                idx = fuf_sel_t'(i - 1);
            end
        end
    end

endmodule

// File: rtl/fuf_fwd_tracker.sv
// Tracks FUF bus destination tags and registers per-port live/delayed forward select codes.
// Optional duplicate-tag checker and dup_err port enabled by FUF_FWD_DUPCHK_EN.
module fuf_fwd_tracker
    import fuf_pkg::*;
#(
    parameter int unsigned BUSES = FUF_BUSES,
    parameter int unsigned PORTS = FUF_PORTS,
    parameter int unsigned REG_W = FUF_REG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUSES-1:0]       wb_en,
    input  logic [BUSES*REG_W-1:0] wb_reg,
    input  logic                   flush,
    input  logic [PORTS-1:0]       q_en,
    input  logic [PORTS*REG_W-1:0] q_reg,
    output logic [PORTS*4-1:0]     fufwd,
    output logic [PORTS*4-1:0]     fuufwd
`ifdef FUF_FWD_DUPCHK_EN
    ,
    output logic                   dup_err
`endif
);

    // Only S1 is stored: a code registered from S1 already points at FUFk_reg in the cycle
    // the consumer uses it, so an S2 copy would never be compared against.
    logic [BUSES-1:0]       s1_vld;
    logic [BUSES*REG_W-1:0] s1_reg;

    logic     live_hit [PORTS];
    logic     s1_hit   [PORTS];
    fuf_sel_t live_idx [PORTS];
    fuf_sel_t s1_idx   [PORTS];

    logic [PORTS*4-1:0] fwd_nxt;
    logic [PORTS*4-1:0] ufwd_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= '0;
            s1_reg <= '0;
        end else begin
            s1_vld <= flush ? '0 : wb_en;
            s1_reg <= wb_reg;
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        fuf_prio_match #(.BUSES(BUSES), .REG_W(REG_W)) u_live (
            .valid (wb_en),
            .tags  (wb_reg),
            .key   (q_reg[p*REG_W +: REG_W]),
            .hit   (live_hit[p]),
            .idx   (live_idx[p])
        );
        fuf_prio_match #(.BUSES(BUSES), .REG_W(REG_W)) u_s1 (
            .valid (s1_vld),
            .tags  (s1_reg),
            .key   (q_reg[p*REG_W +: REG_W]),
            .hit   (s1_hit[p]),
            .idx   (s1_idx[p])
        );
    end

    // A live hit is the newer result and suppresses the delayed select.
    always_comb begin
        fwd_nxt  = '1;
        ufwd_nxt = '1;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (!flush && q_en[p]) begin
                if (live_hit[p]) begin
                    fwd_nxt[p*4 +: 4] = live_idx[p];
                end else if (s1_hit[p]) begin
                    ufwd_nxt[p*4 +: 4] = s1_idx[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fufwd  <= '1;
            fuufwd <= '1;
        end else begin
            fufwd  <= fwd_nxt;
            fuufwd <= ufwd_nxt;
        end
    end

`ifdef FUF_FWD_DUPCHK_EN
    logic        dup_hit;
    logic [15:0] dup_cnt;

    always_comb begin
        dup_hit = 1'b0;
        for (int unsigned i = 0; i < BUSES; i++) begin
            for (int unsigned j = i + 1; j < BUSES; j++) begin
                if (wb_en[i] && wb_en[j] &&
                    (wb_reg[i*REG_W +: REG_W] == wb_reg[j*REG_W +: REG_W])) begin
                    dup_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dup_err <= 1'b0;
            dup_cnt <= '0;
        end else if (dup_hit) begin
            dup_err <= 1'b1;
            if (dup_cnt != '1) begin
                dup_cnt <= dup_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fuf_fwd_tracker.sv
// Scoreboard bench for fuf_fwd_tracker: directed forwarding scenarios, random traffic, async reset.
module tb_fuf_fwd_tracker;

    localparam int NB = 10;
    localparam int NP = 6;
    localparam int RW = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NB-1:0]     wb_en = '0;
    logic [NB*RW-1:0]  wb_reg = '0;
    logic              flush = 1'b0;
    logic [NP-1:0]     q_en = '0;
    logic [NP*RW-1:0]  q_reg = '0;
    logic [NP*4-1:0]   fufwd;
    logic [NP*4-1:0]   fuufwd;
`ifdef FUF_FWD_DUPCHK_EN
    logic              dup_err;
`endif

    fuf_fwd_tracker #(.BUSES(NB), .PORTS(NP), .REG_W(RW)) dut (
        .clk    (clk),
        .rst    (rst),
        .wb_en  (wb_en),
        .wb_reg (wb_reg),
        .flush  (flush),
        .q_en   (q_en),
        .q_reg  (q_reg),
        .fufwd  (fufwd),
        .fuufwd (fuufwd)
`ifdef FUF_FWD_DUPCHK_EN
        ,
        .dup_err(dup_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   bus;
        logic [RW-1:0] tag;
    } ann_t;

    typedef struct {
        int             cyc;
        logic [NP*4-1:0] fw;
        logic [NP*4-1:0] uf;
    } exp_t;

    ann_t ann_q[$];
    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [NB-1:0] a_en;
    logic [RW-1:0] a_tag [NB];
    logic [NP-1:0] a_qen;
    logic [RW-1:0] a_q   [NP];
    logic          a_fl;

    task automatic a_clear();
        a_en = '0;
        a_qen = '0;
        a_fl = 1'b0;
        for (int b = 0; b < NB; b++) a_tag[b] = '0;
        for (int p = 0; p < NP; p++) a_q[p] = '0;
    endtask

    // Drive one cycle of stimulus and predict the codes registered at the next edge.
    task automatic apply();
        exp_t e;
        int   fw;
        int   uf;
        @(negedge clk);
        wb_en = a_en;
        flush = a_fl;
        q_en  = a_qen;
        for (int b = 0; b < NB; b++) wb_reg[b*RW +: RW] = a_tag[b];
        for (int p = 0; p < NP; p++) q_reg[p*RW +: RW] = a_q[p];
        e.cyc = cyc;
        for (int p = 0; p < NP; p++) begin
            fw = 15;
            uf = 15;
            if (a_qen[p] && !a_fl) begin
                for (int b = 0; b < NB; b++)
                    if (a_en[b] && a_tag[b] == a_q[p] && fw == 15) fw = b;
                foreach (ann_q[i])
                    if (ann_q[i].cyc == cyc - 1 && ann_q[i].tag == a_q[p] && ann_q[i].bus < uf)
                        uf = ann_q[i].bus;
                if (fw != 15) uf = 15;
            end
            e.fw[p*4 +: 4] = 4'(fw);
            e.uf[p*4 +: 4] = 4'(uf);
        end
        exp_q.push_back(e);
        while (ann_q.size() > 0 && ann_q[0].cyc < cyc) void'(ann_q.pop_front());
        if (!a_fl) begin
            for (int b = 0; b < NB; b++)
                if (a_en[b]) ann_q.push_back('{cyc, b, a_tag[b]});
        end
        cyc++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NP; p++) begin
                    vectors++;
                    if (fufwd[p*4 +: 4] !== e.fw[p*4 +: 4] || fuufwd[p*4 +: 4] !== e.uf[p*4 +: 4]) begin
                        miscompares++;
                        $display("FAIL codes cyc%0d port%0d: fufwd=%h fuufwd=%h, expected %h %h",
                                 e.cyc, p, fufwd[p*4 +: 4], fuufwd[p*4 +: 4],
                                 e.fw[p*4 +: 4], e.uf[p*4 +: 4]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_all_none(input string name);
        vectors++;
        if (fufwd !== '1 || fuufwd !== '1) begin
            miscompares++;
            $display("FAIL %s: fufwd=%h fuufwd=%h, expected all F", name, fufwd, fuufwd);
        end
    endtask

    initial begin : stim
        a_clear();
        #12;
        check_all_none("reset_state");
`ifdef FUF_FWD_DUPCHK_EN
        vectors++;
        if (dup_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dup_err: got %b expected 0", dup_err);
        end
`endif
        @(negedge clk);
        rst = 1'b0;

        // live forward
        a_clear();
        a_en[3] = 1'b1; a_tag[3] = 9'h021; a_qen[0] = 1'b1; a_q[0] = 9'h021;
        apply();
        a_clear(); apply();

        // delayed forward, then expiry
        a_clear(); a_en[7] = 1'b1; a_tag[7] = 9'h021; apply();
        a_clear(); a_qen[2] = 1'b1; a_q[2] = 9'h021; apply();
        a_clear(); a_qen[2] = 1'b1; a_q[2] = 9'h021; apply();

        // newer wins
        a_clear(); a_en[1] = 1'b1; a_tag[1] = 9'h050; apply();
        a_clear(); a_en[8] = 1'b1; a_tag[8] = 9'h050; a_qen[4] = 1'b1; a_q[4] = 9'h050; apply();

        // lowest index among duplicates
        a_clear();
        a_en[2] = 1'b1; a_tag[2] = 9'h0AA; a_en[5] = 1'b1; a_tag[5] = 9'h0AA;
        a_qen[1] = 1'b1; a_q[1] = 9'h0AA;
        apply();
        a_clear(); a_qen[1] = 1'b1; a_q[1] = 9'h0AA; apply();
`ifdef FUF_FWD_DUPCHK_EN
        vectors++;
        if (dup_err !== 1'b1) begin
            miscompares++;
            $display("FAIL dup_err_set: got %b expected 1", dup_err);
        end
`endif

        // flush
        a_clear(); a_en[0] = 1'b1; a_tag[0] = 9'h011; apply();
        a_clear(); a_fl = 1'b1; a_en[4] = 1'b1; a_tag[4] = 9'h011;
        for (int p = 0; p < NP; p++) begin a_qen[p] = 1'b1; a_q[p] = 9'h011; end
        apply();
        a_clear(); a_qen[3] = 1'b1; a_q[3] = 9'h011; apply();

        // random traffic on a narrow tag range so matches and collisions are frequent
        for (int n = 0; n < 2000; n++) begin
            a_clear();
            for (int b = 0; b < NB; b++) begin
                a_en[b]  = ($urandom_range(0, 9) < 3);
                a_tag[b] = 9'(32 + $urandom_range(0, 7));
            end
            for (int p = 0; p < NP; p++) begin
                a_qen[p] = ($urandom_range(0, 3) != 0);
                a_q[p]   = 9'(32 + $urandom_range(0, 7));
            end
            a_fl = ($urandom_range(0, 19) == 0);
            apply();
        end

        // asynchronous reset while a live forward is being presented
        a_clear(); a_en[6] = 1'b1; a_tag[6] = 9'h033; apply();
        a_clear(); a_en[3] = 1'b1; a_tag[3] = 9'h033; a_qen[5] = 1'b1; a_q[5] = 9'h033; apply();
        @(posedge clk);
        #3;
        rst = 1'b1;
        wb_en = '0; q_en = '0; flush = 1'b0;
        exp_q.delete();
        ann_q.delete();
        #1;
        check_all_none("async_reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        a_clear(); a_qen[5] = 1'b1; a_q[5] = 9'h033; apply();
        a_clear(); apply();

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
